// File: rtl/counter_arbiter_pkg.sv
// Shared types and constants for the two-requester counter arbiter.
package counter_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int CW_DEFAULT = 4;
    localparam int NUM_REQ    = 2;

    // Turn a requester index into its one-hot grant/done vector
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
        logic [NUM_REQ-1:0] vec;
        if (idx) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

    // Round-robin pick: on a tie the requester named by prio wins,
    // otherwise the single active requester wins.
    function automatic logic rr_pick(input logic [NUM_REQ-1:0] req, input logic prio);
        logic win;
        if (req == 2'b11) begin
            win = prio;
        end else if (req[1]) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
        return win;
    endfunction

endpackage

// File: rtl/counter_arbiter_counter.sv
// Shared run-length counter: clear has priority over enable, never wraps.
module arb_counter
    import counter_arbiter_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    // Next-count selection: clear, increment (saturating at all-ones), or hold
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {CW{1'b1}})) begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that grants one shared counter run
// of a requester-supplied length and pulses done back to the owner.
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [CW-1:0] len0,
    input  logic [CW-1:0] len1,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic [1:0]    done
);

    state_e        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] len_q, len_d;
    logic          owner_q, owner_d;
    logic          prio_q, prio_d;

    logic          win_s;
    logic          cnt_clr_s;
    logic          cnt_en_s;
    logic [CW-1:0] count_s;

    arb_counter #(.CW(CW)) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .count (count_s)
    );

    // FSM next-state, arbitration and registered-output next values
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = 2'b00;
        busy_d    = busy_q;
        len_d     = len_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        win_s     = rr_pick(req, prio_q);
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    state_d   = ST_RUN;
                    gnt_d     = idx_to_onehot(win_s);
                    busy_d    = 1'b1;
                    len_d     = win_s ? len1 : len0;
                    owner_d   = win_s;
                    // The winner drops to lowest priority for the next tie
                    prio_d    = ~win_s;
                    cnt_clr_s = 1'b1;
                end else begin
                    gnt_d  = 2'b00;
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (count_s != len_q) begin
                    cnt_en_s = 1'b1;
                end else begin
                    state_d = ST_DONE;
                    gnt_d   = 2'b00;
                    done_d  = idx_to_onehot(owner_q);
                end
            end
            ST_DONE: begin
                // Count is cleared on the way out so IDLE always shows zero
                state_d   = ST_IDLE;
                gnt_d     = 2'b00;
                busy_d    = 1'b0;
                cnt_clr_s = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                gnt_d     = 2'b00;
                busy_d    = 1'b0;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // FSM state and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            len_q   <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            len_q   <= len_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = count_s;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed table-driven bench for counter_arbiter plus a round-robin sequence.
module tb_counter_arbiter;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [CW-1:0] len0;
    logic [CW-1:0] len1;
    logic [1:0]    gnt;
    logic          busy;
    logic [CW-1:0] count;
    logic [1:0]    done;

    int tests_run    = 0;
    int tests_failed = 0;
    logic chk_en = 1'b0;

    counter_arbiter #(.CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len0  (len0),
        .len1  (len1),
        .gnt   (gnt),
        .busy  (busy),
        .count (count),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [1:0]    req;
        logic [CW-1:0] l0;
        logic [CW-1:0] l1;
        logic [1:0]    gnt;
        logic [1:0]    done;
        logic          busy;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [1:0] rq, input int l0, input int l1,
                                input logic [1:0] g, input logic [1:0] d, input logic b, input int c);
        vec_t v;
        v.rst  = r;
        v.req  = rq;
        v.l0   = CW'(l0);
        v.l1   = CW'(l1);
        v.gnt  = g;
        v.done = d;
        v.busy = b;
        v.cnt  = CW'(c);
        vecs.push_back(v);
    endfunction

    // Protocol invariants sampled on the falling edge
    logic [1:0]    prev_gnt = 2'b00;
    logic [CW-1:0] prev_cnt = '0;
    always @(negedge clk) begin
        if (chk_en) begin
            tests_run++;
            if (!$onehot0(gnt) || !$onehot0(done) || ((gnt != 2'b00) && (done != 2'b00))) begin
                tests_failed++;
                $display("FAIL onehot: gnt=%b done=%b required at most one-hot and disjoint", gnt, done);
            end
            if ((prev_gnt != 2'b00) && (gnt == prev_gnt) && (count < prev_cnt)) begin
                tests_failed++;
                $display("FAIL monotonic: count=%0d after %0d within a run", count, prev_cnt);
            end
            prev_gnt = gnt;
            prev_cnt = count;
        end
    end

    initial begin
        int grants[$];
        int dones[$];
        int exp_seq[4];
        int cyc;
        logic [1:0] last_gnt;

        reset = 1'b0;
        req   = 2'b00;
        len0  = '0;
        len1  = '0;

        // Basic run with len0=3
        add(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        add(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        add(1, 2'b01, 3, 0, 2'b01, 2'b00, 1, 0);
        for (int k = 1; k <= 3; k++) add(1, 2'b00, 3, 0, 2'b01, 2'b00, 1, k);
        add(1, 2'b00, 3, 0, 2'b00, 2'b01, 1, 3);
        add(1, 2'b00, 3, 0, 2'b00, 2'b00, 0, 0);
        // len0=0: single RUN cycle
        add(1, 2'b01, 0, 0, 2'b01, 2'b00, 1, 0);
        add(1, 2'b00, 0, 0, 2'b00, 2'b01, 1, 0);
        add(1, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0);
        // len0=15: count to all-ones without wrap
        add(1, 2'b01, 15, 0, 2'b01, 2'b00, 1, 0);
        for (int k = 1; k <= 15; k++) add(1, 2'b00, 15, 0, 2'b01, 2'b00, 1, k);
        add(1, 2'b00, 15, 0, 2'b00, 2'b01, 1, 15);
        add(1, 2'b00, 15, 0, 2'b00, 2'b00, 0, 0);
        // len0=6, then len0 changed to 1 and req dropped mid-run
        add(1, 2'b01, 6, 0, 2'b01, 2'b00, 1, 0);
        for (int k = 1; k <= 6; k++) add(1, 2'b00, 1, 0, 2'b01, 2'b00, 1, k);
        add(1, 2'b00, 1, 0, 2'b00, 2'b01, 1, 6);
        add(1, 2'b00, 1, 0, 2'b00, 2'b00, 0, 0);
        // Reset at count=2 aborts the run, then requester 1 alone
        add(1, 2'b01, 5, 0, 2'b01, 2'b00, 1, 0);
        add(1, 2'b00, 5, 0, 2'b01, 2'b00, 1, 1);
        add(1, 2'b00, 5, 0, 2'b01, 2'b00, 1, 2);
        add(0, 2'b00, 5, 0, 2'b00, 2'b00, 0, 0);
        add(1, 2'b00, 5, 0, 2'b00, 2'b00, 0, 0);
        add(1, 2'b00, 5, 0, 2'b00, 2'b00, 0, 0);
        add(1, 2'b10, 5, 1, 2'b10, 2'b00, 1, 0);
        add(1, 2'b00, 5, 1, 2'b10, 2'b00, 1, 1);
        add(1, 2'b00, 5, 1, 2'b00, 2'b10, 1, 1);
        add(1, 2'b00, 5, 1, 2'b00, 2'b00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            req   = vecs[i].req;
            len0  = vecs[i].l0;
            len1  = vecs[i].l1;
            @(posedge clk);
            #1;
            chk_en = 1'b1;
            tests_run++;
            if ({gnt, done, busy, count} !== {vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].cnt}) begin
                tests_failed++;
                $display("FAIL vec%0d: got gnt=%b done=%b busy=%b count=%0d, want gnt=%b done=%b busy=%b count=%0d",
                         i, gnt, done, busy, count, vecs[i].gnt, vecs[i].done, vecs[i].busy, vecs[i].cnt);
            end
        end

        // Both requesters held high from reset: grants must alternate 0,1,0,1
        reset = 1'b0;
        req   = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b1;
        req      = 2'b11;
        len0     = 4'd1;
        len1     = 4'd2;
        last_gnt = 2'b00;
        cyc      = 0;
        while ((dones.size() < 4) && (cyc < 100)) begin
            @(posedge clk);
            #1;
            cyc++;
            if ((gnt != 2'b00) && (last_gnt == 2'b00)) grants.push_back(gnt == 2'b10 ? 1 : (gnt == 2'b01 ? 0 : 2));
            if (done != 2'b00) dones.push_back(done == 2'b10 ? 1 : (done == 2'b01 ? 0 : 2));
            if (grants.size() >= 4) req = 2'b00;
            last_gnt = gnt;
        end
        tests_run++;
        if (cyc >= 100) begin
            tests_failed++;
            $display("FAIL rr_timeout: saw %0d done pulses, required 4 within 100 cycles", dones.size());
        end
        exp_seq = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if ((i >= grants.size()) || (grants[i] != exp_seq[i])) begin
                tests_failed++;
                $display("FAIL rr_grant%0d: got %0d, want %0d", i, (i < grants.size()) ? grants[i] : -1, exp_seq[i]);
            end
            tests_run++;
            if ((i >= dones.size()) || (dones[i] != exp_seq[i])) begin
                tests_failed++;
                $display("FAIL rr_done%0d: got %0d, want %0d", i, (i < dones.size()) ? dones[i] : -1, exp_seq[i]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({gnt, done, busy} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL rr_idle: got gnt=%b done=%b busy=%b, want all 0", gnt, done, busy);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter CW, default 4: width of the shared counter and of each run-length input.
REQ-002 The block SHALL provide port clk, input, 1: single rising-edge clock for all state.
REQ-003 The block SHALL provide port reset, input, 1: synchronous, active-low reset, sampled on the clk rising edge only.
REQ-004 The block SHALL provide port req, input, 2: per-requester run request, held high until granted.
REQ-005 The block SHALL provide port len0, input, CW: requester-0 terminal count, sampled at grant only.
REQ-006 The block SHALL provide port len1, input, CW: requester-1 terminal count, sampled at grant only.
REQ-007 The block SHALL provide port gnt, output, 2: one-hot grant, high for the whole RUN phase of the owner.
REQ-008 The block SHALL provide port busy, output, 1: high in RUN and DONE states.
REQ-009 The block SHALL provide port count, output, CW: shared counter value.
REQ-010 The block SHALL provide port done, output, 2: one-cycle completion pulse to the owner.

Function
REQ-011 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE with req==0 SHALL hold IDLE, with gnt=0, done=0, busy=0, and count holding 0.
REQ-013 IDLE with any req bit set SHALL select one winner, latch its len into len_q, clear count to 0, set gnt[winner], and enter RUN on the next edge.
REQ-014 Arbitration SHALL be round-robin: the last-granted requester has the lower priority; on simultaneous requests with no history (after reset), requester 0 wins.
REQ-015 The priority pointer SHALL update only on a grant, never on done.
REQ-016 In RUN, count SHALL increment by 1 per cycle while count != len_q.
REQ-017 In RUN with count==len_q, the FSM SHALL enter DONE on the next edge and count SHALL hold.
REQ-018 Entering DONE SHALL clear gnt and raise done[owner] for exactly one cycle; DONE SHALL return to IDLE unconditionally.
REQ-019 Timing: req sampled in IDLE at edge T SHALL give gnt high from T+1 with count=0, count==len at T+1+len, done pulse at T+2+len, IDLE at T+3+len, and the earliest next grant at T+4+len.
REQ-020 len=0 SHALL give exactly one RUN cycle with count 0.
REQ-021 len=2^CW-1 SHALL count to all-ones without wrap; count SHALL never wrap in any state.
REQ-022 Changes on len0/len1 after grant, or deassertion of req during RUN or DONE, SHALL be ignored; the run SHALL complete.
REQ-023 A req still high in IDLE after done SHALL be re-arbitrated per the pointer, so back-to-back requests from both requesters alternate.
REQ-024 gnt SHALL be at most one-hot, done SHALL be at most one-hot, and done SHALL never coincide with gnt.

Reset
REQ-025 reset=0 at an edge SHALL force the IDLE state, gnt=0, done=0, busy=0, count=0, len_q=0, and a priority pointer favouring requester 0.
REQ-026 reset asserted mid-RUN or mid-DONE SHALL abort the run with no done pulse; normal operation SHALL resume on the first edge with reset=1.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE), the CW default, and the requester-count constant (2).
REQ-028 The counter datapath (clear, enable, hold; CW bits) SHALL be a single sub-module, arb_counter; the arbitration and FSM logic SHALL stay in counter_arbiter.
REQ-029 All outputs SHALL be registered, with no combinational path from any input to any output.

Verification
REQ-030 The bench SHALL drive reset low for 2 cycles, then req=01 with len0=3, and check gnt=01 from T+1, count sequence 0,1,2,3, done=01 at T+5, and busy low at T+6.
REQ-031 The bench SHALL hold req=11 from reset with len0=1 and len1=2, and check grant order 0,1,0,1 with done pulses alternating and no overlap.
REQ-032 The bench SHALL check that len0=0 gives exactly one gnt cycle with count=0, and that len0=15 gives count reaching 15 without wrap, followed by done.
REQ-033 The bench SHALL change len0 to 1 and drop req mid-run (original len0=6), and check that the run still ends at count=6 with done=01.
REQ-034 The bench SHALL drive reset low during RUN at count=2, and check that all outputs are 0 on the next edge, no done pulse occurs, and a later req=10 is granted to requester 1 first.
REQ-035 Bench assertions SHALL check gnt and done at most one-hot, and count never decreasing within a run.
